// File: rtl/dual_port_ram_sweep.sv
// True dual-port RAM with per-lane write enables, per-port read-during-write modes and a post-reset clear sweep.
// Optional sticky collision flag is enabled by defining DUAL_PORT_RAM_SWEEP_COLLISION_EN.
module dual_port_ram_sweep #(
  parameter int DATA_WIDTH = 14,
  parameter int ADDR_WIDTH = 6,
  parameter int LANE_WIDTH = 7,
  parameter int PORT1_MODE = 1,
  parameter int PORT2_MODE = 0,
  parameter int OUT_REG    = 0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
  localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  busy,
  input  logic [ADDR_WIDTH-1:0] port1_addr,
  input  logic [DATA_WIDTH-1:0] port1_data_in,
  input  logic [NUM_LANES-1:0]  port1_write_en,
  input  logic                  port1_read_en,
  output logic [DATA_WIDTH-1:0] port1_data_out,
  output logic                  port1_read_valid,
  input  logic [ADDR_WIDTH-1:0] port2_addr,
  input  logic [DATA_WIDTH-1:0] port2_data_in,
  input  logic [NUM_LANES-1:0]  port2_write_en,
  input  logic                  port2_read_en,
  output logic [DATA_WIDTH-1:0] port2_data_out,
  output logic                  port2_read_valid,
`ifdef DUAL_PORT_RAM_SWEEP_COLLISION_EN
  output logic                  collision,
`endif
  output logic                  dbg_state
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {S_CLEAR = 1'b0, S_READY = 1'b1} state_e;

  state_e                r_state;
  state_e                w_next_state;
  logic [ADDR_WIDTH-1:0] r_count;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_ready;
  logic [NUM_LANES-1:0]  w_p1_we;
  logic [NUM_LANES-1:0]  w_p2_we;
  logic [DATA_WIDTH-1:0] w_p1_old;
  logic [DATA_WIDTH-1:0] w_p2_old;
  logic [DATA_WIDTH-1:0] w_p1_merged;
  logic [DATA_WIDTH-1:0] w_p2_merged;
  logic [DATA_WIDTH-1:0] w_p1_rdata;
  logic [DATA_WIDTH-1:0] w_p2_rdata;
  logic                  w_p1_rd;
  logic                  w_p2_rd;

  logic [DATA_WIDTH-1:0] r_p1_q;
  logic [DATA_WIDTH-1:0] r_p2_q;
  logic                  r_p1_v;
  logic                  r_p2_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_CLEAR;
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_CLEAR) r_count <= r_count + 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_CLEAR: if (r_count == ADDR_WIDTH'(DEPTH - 1)) w_next_state = S_READY;
      S_READY: w_next_state = S_READY;
      default: w_next_state = S_CLEAR;
    endcase
  end

  assign busy      = (r_state == S_CLEAR);
  assign dbg_state = r_state;

  // Port traffic only counts in READY and never on a reset edge.
  assign w_ready = (r_state == S_READY) && !rst;
  assign w_p1_we = port1_write_en & {NUM_LANES{w_ready}};
  assign w_p2_we = port2_write_en & {NUM_LANES{w_ready}};

  // Port2 lanes are written first so port1 overrides on overlapping lanes.
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_mem[r_count] <= CLEAR_VALUE;
    end else begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (w_p2_we[l]) r_mem[port2_addr][l*LANE_WIDTH +: LANE_WIDTH] <= port2_data_in[l*LANE_WIDTH +: LANE_WIDTH];
      end
      for (int l = 0; l < NUM_LANES; l++) begin
        if (w_p1_we[l]) r_mem[port1_addr][l*LANE_WIDTH +: LANE_WIDTH] <= port1_data_in[l*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  assign w_p1_old = r_mem[port1_addr];
  assign w_p2_old = r_mem[port2_addr];

  // Write-first data merges only this port's own lanes; the other port's write is never visible.
  always_comb begin
    w_p1_merged = w_p1_old;
    w_p2_merged = w_p2_old;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (port1_write_en[l]) w_p1_merged[l*LANE_WIDTH +: LANE_WIDTH] = port1_data_in[l*LANE_WIDTH +: LANE_WIDTH];
      if (port2_write_en[l]) w_p2_merged[l*LANE_WIDTH +: LANE_WIDTH] = port2_data_in[l*LANE_WIDTH +: LANE_WIDTH];
    end
  end

  assign w_p1_rdata = (PORT1_MODE == 1) ? w_p1_merged : w_p1_old;
  assign w_p2_rdata = (PORT2_MODE == 1) ? w_p2_merged : w_p2_old;
  assign w_p1_rd    = w_ready && port1_read_en && !((PORT1_MODE == 2) && (|port1_write_en));
  assign w_p2_rd    = w_ready && port2_read_en && !((PORT2_MODE == 2) && (|port2_write_en));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p1_q <= '0;
      r_p2_q <= '0;
      r_p1_v <= 1'b0;
      r_p2_v <= 1'b0;
    end else begin
      r_p1_v <= w_p1_rd;
      r_p2_v <= w_p2_rd;
      if (w_p1_rd) r_p1_q <= w_p1_rdata;
      if (w_p2_rd) r_p2_q <= w_p2_rdata;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] r_p1_q2;
      logic [DATA_WIDTH-1:0] r_p2_q2;
      logic                  r_p1_v2;
      logic                  r_p2_v2;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_p1_q2 <= '0;
          r_p2_q2 <= '0;
          r_p1_v2 <= 1'b0;
          r_p2_v2 <= 1'b0;
        end else begin
          r_p1_v2 <= r_p1_v;
          r_p2_v2 <= r_p2_v;
          if (r_p1_v) r_p1_q2 <= r_p1_q;
          if (r_p2_v) r_p2_q2 <= r_p2_q;
        end
      end

      assign port1_data_out   = r_p1_q2;
      assign port1_read_valid = r_p1_v2;
      assign port2_data_out   = r_p2_q2;
      assign port2_read_valid = r_p2_v2;
    end else begin : g_no_out_reg
      assign port1_data_out   = r_p1_q;
      assign port1_read_valid = r_p1_v;
      assign port2_data_out   = r_p2_q;
      assign port2_read_valid = r_p2_v;
    end
  endgenerate

`ifdef DUAL_PORT_RAM_SWEEP_COLLISION_EN
  logic r_collision;
  logic w_same_addr;

  assign w_same_addr = (port1_addr == port2_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_collision <= 1'b0;
    end else if (w_ready && w_same_addr &&
                 ((|(port1_write_en & port2_write_en)) ||
                  ((|port1_write_en) && port2_read_en) ||
                  ((|port2_write_en) && port1_read_en))) begin
      r_collision <= 1'b1;
    end
  end

  assign collision = r_collision;
`endif

endmodule

// File: doc/dual_port_ram_sweep.md
Name: dual_port_ram_sweep

Overview:
- Parametrised true dual-port synchronous RAM with independent read/write on both ports, per-lane write enables and a per-port read-during-write mode.
- Both ports have registered reads with an optional output pipeline stage, plus read-valid tracking.
- After reset, a hardware sweep clears every word to a known value.
- Generalises the earlier fixed 14x64 single-clock RAM. Used as register-file and buffer storage throughout the design.

Parameters:
- DATA_WIDTH, 14, word width in bits.
- ADDR_WIDTH, 6, address bits; depth = 2**ADDR_WIDTH.
- LANE_WIDTH, 7, write-enable granularity; DATA_WIDTH must be a multiple of it; NUM_LANES = DATA_WIDTH/LANE_WIDTH.
- PORT1_MODE, 1, port1 read-during-write: 0 read-first (old data), 1 write-first (new data), 2 no-change (data_out holds).
- PORT2_MODE, 0, same encoding for port2.
- OUT_REG, 0, 1 adds one output register stage on both ports.
- CLEAR_VALUE, 0, word written to every address during the reset sweep.

Ports:
- clk  in  1  single clock for both ports.
- rst  in  1  synchronous, active-high reset.
- busy  out  1  high while the clear sweep runs; port requests are ignored.
- port1_addr  in  ADDR_WIDTH  port1 address.
- port1_data_in  in  DATA_WIDTH  port1 write data.
- port1_write_en  in  NUM_LANES  port1 per-lane write enable.
- port1_read_en  in  1  port1 read request.
- port1_data_out  out  DATA_WIDTH  port1 read data.
- port1_read_valid  out  1  port1_data_out carries a new read result.
- port2_addr, port2_data_in, port2_write_en, port2_read_en, port2_data_out, port2_read_valid: same as port1, for port2.

Behaviour:
- Clock/reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values:
  - data_out = 0 and read_valid = 0 on both ports.
  - busy = 1 in the cycle after rst is sampled high.
- Sweep FSM states: CLEAR, READY.
- CLEAR:
  - Internal counter starts at 0 and writes CLEAR_VALUE to mem[counter] each cycle.
  - Leaves after writing address 2**ADDR_WIDTH-1, so the sweep takes exactly 2**ADDR_WIDTH cycles, then goes to READY.
  - busy = 1 throughout. All port write/read enables are ignored; read_valid stays 0.
- READY: busy = 0; normal operation. The FSM returns to CLEAR only on rst.
- rst asserted mid-sweep: counter restarts at 0 and a full sweep reruns.
- Writes: lane i of mem[addr] is updated at the clock edge when write_en[i]=1; other lanes are unchanged.
- Reads:
  - A read with read_en=1 at edge N puts data on data_out after edge N when OUT_REG=0, or after edge N+1 when OUT_REG=1.
  - read_valid is asserted aligned with that data, for exactly one cycle per request.
  - Back-to-back reads give one result per cycle, with no bubbles.
- data_out holds its last value when there is no read. It is never cleared except by rst.
- Same-port read and write at the same address and edge:
  - mode 0: old word.
  - mode 1: merged new word (written lanes new, unwritten lanes old).
  - mode 2: no read is performed; data_out holds and read_valid = 0.
- Cross-port write collision (both ports write the same address, overlapping lanes, same edge): port1 wins on the overlapping lanes; non-overlapping lanes from both ports are applied.
- Cross-port read of an address the other port writes on the same edge: returns the old word, regardless of mode.
- Width rules: addresses are used unsigned with no wrap logic needed. Depth is always a power of two, so every address is valid.

Optional Feature:
- Macro: DUAL_PORT_RAM_SWEEP_COLLISION_EN.
- Defined:
  - Adds output port collision (1 bit), a sticky flag.
  - Set at the edge where both ports write overlapping lanes of the same address, or where one port writes and the other reads the same address.
  - Cleared only by rst; reset value 0.
  - Collisions during CLEAR are not possible and are not flagged.
- Undefined: port and logic absent; collision resolution as above is unchanged.

Test Plan:
- Sweep: assert rst 1 cycle with CLEAR_VALUE=0x155. Then:
  - busy = 1 for exactly 64 cycles, then 0.
  - Reads of addresses 0, 31 and 63 return 0x155.
  - read_valid stays 0 during the sweep even with read_en=1.
- Latency:
  - OUT_REG=0: write 0x2A5A to port1 address 5, then read port2 address 5 at edge N → data_out_b = 0x2A5A and read_valid_b = 1 after edge N.
  - OUT_REG=1: same sequence, with data and valid one cycle later.
- Byte lanes: mem[9]=0x3FFF, then port1 writes 0x0000 with write_en=2'b01 → read returns 0x3F80.
- Read-during-write on port1 at address 3 (old 0x0011, new 0x0022):
  - mode 0 returns 0x0011.
  - mode 1 returns 0x0022.
  - mode 2 leaves data_out unchanged and read_valid=0.
  - mem[3] = 0x0022 in all three modes.
- Collision: both ports write address 7 with full lanes (port1 0x1111, port2 0x2222) → mem[7] = 0x1111. With the macro defined, collision = 1 and stays 1 until rst.
- Reset mid-sweep: assert rst at sweep cycle 20 → busy stays high for a full 64 cycles from the new reset, and every address reads CLEAR_VALUE.
